// File: rtl/wb_manager_rr_arbiter.sv
// Round-robin Wishbone manager arbiter: one grant per bus cycle, held for the whole CYC.
// Optional watchdog enabled by WB_ARB_TIMEOUT_EN terminates cycles the slave never acknowledges.
module wb_manager_rr_arbiter #(
    parameter int unsigned NUM_MANAGERS   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [32*NUM_MANAGERS-1:0] A_ADR_I,
    input  logic [32*NUM_MANAGERS-1:0] A_DAT_I,
    input  logic [4*NUM_MANAGERS-1:0]  A_SEL_I,
    input  logic [NUM_MANAGERS-1:0]    A_WE_I,
    input  logic [NUM_MANAGERS-1:0]    A_STB_I,
    input  logic [NUM_MANAGERS-1:0]    A_CYC_I,
    output logic [32*NUM_MANAGERS-1:0] A_DAT_O,
    output logic [NUM_MANAGERS-1:0]    A_ACK_O,
    output logic [31:0]                ADR_O,
    output logic [31:0]                DAT_O,
    output logic [3:0]                 SEL_O,
    output logic                       WE_O,
    output logic                       STB_O,
    output logic                       CYC_O,
    input  logic [31:0]                DAT_I,
    input  logic                       ACK_I,
    output logic [NUM_MANAGERS-1:0]    grant_o,
    output logic                       timeout_o
);

    localparam int unsigned IdxW = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StTmo} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] gidx_q, gidx_d;
    logic [IdxW-1:0] last_q, last_d;
    logic            req_any;
    logic [IdxW-1:0] req_idx;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    // Rotating search: lowest requester above last wins, otherwise lowest requester overall.
    always_comb begin
        req_any = |A_CYC_I;
        req_idx = '0;
        for (int i = int'(NUM_MANAGERS) - 1; i >= 0; i--) begin
            if (A_CYC_I[i]) req_idx = IdxW'(i);
        end
        for (int i = int'(NUM_MANAGERS) - 1; i >= 0; i--) begin
            if (A_CYC_I[i] && (i > int'(last_q))) req_idx = IdxW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        grant_o   = '0;
        ADR_O     = '0;
        DAT_O     = '0;
        SEL_O     = '0;
        WE_O      = 1'b0;
        STB_O     = 1'b0;
        CYC_O     = 1'b0;
        A_ACK_O   = '0;
        A_DAT_O   = '0;
        timeout_o = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
        case (state_q)
            StIdle: begin
                if (req_any) begin
                    gidx_d  = req_idx;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                grant_o[gidx_q] = 1'b1;
                ADR_O = A_ADR_I[32*gidx_q +: 32];
                DAT_O = A_DAT_I[32*gidx_q +: 32];
                SEL_O = A_SEL_I[4*gidx_q +: 4];
                WE_O  = A_WE_I[gidx_q];
                STB_O = A_STB_I[gidx_q];
                CYC_O = A_CYC_I[gidx_q];
                // An ACK landing as the grantee drops CYC belongs to nobody.
                A_ACK_O[gidx_q]           = ACK_I & A_CYC_I[gidx_q];
                A_DAT_O[32*gidx_q +: 32] = DAT_I;
                if (!A_CYC_I[gidx_q]) begin
                    last_d  = gidx_q;
                    state_d = StIdle;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (ACK_I) begin
                    cnt_d = '0;
                end else if (A_STB_I[gidx_q]) begin
                    if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) state_d = StTmo;
                    else cnt_d = cnt_q + CntW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            StTmo: begin
                grant_o[gidx_q]           = 1'b1;
                A_ACK_O[gidx_q]           = 1'b1;
                A_DAT_O[32*gidx_q +: 32] = 32'hDEAD_BEEF;
                timeout_o                 = 1'b1;
                if (A_CYC_I[gidx_q]) begin
                    state_d = StBusy;
                end else begin
                    last_d  = gidx_q;
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            gidx_q  <= '0;
            last_q  <= IdxW'(NUM_MANAGERS - 1);
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_wb_manager_rr_arbiter.sv
// Bench for wb_manager_rr_arbiter: vector table, scoreboard of expected acks, corner sequences.
module tb_wb_manager_rr_arbiter;

    localparam logic [31:0] K = 32'h3000_1230;  // slave read data = address ^ K

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] a_adr = '0, a_dat = '0;
    logic [7:0]  a_sel = '0;
    logic [1:0]  a_we = '0, a_stb = '0, a_cyc = '0;
    logic [63:0] a_dat_o;
    logic [1:0]  a_ack_o, grant_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic        we_o, stb_o, cyc_o, timeout_o;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0;

    bit          slave_en = 1'b1;
    int          slave_lat = 0;
    int          scnt = 0;
    logic [1:0]  acked = '0;
    int          errors = 0;
    int          checks = 0;

    typedef struct { int m; logic [31:0] data; } exp_t;
    exp_t sb[$];

    typedef struct {
        int m; logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] wdat; int lat;
        logic [1:0] exp_grant; logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    wb_manager_rr_arbiter #(.NUM_MANAGERS(2), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .A_ADR_I(a_adr), .A_DAT_I(a_dat), .A_SEL_I(a_sel), .A_WE_I(a_we),
        .A_STB_I(a_stb), .A_CYC_I(a_cyc), .A_DAT_O(a_dat_o), .A_ACK_O(a_ack_o),
        .ADR_O(adr_o), .DAT_O(dat_o), .SEL_O(sel_o), .WE_O(we_o), .STB_O(stb_o),
        .CYC_O(cyc_o), .DAT_I(dat_i), .ACK_I(ack_i), .grant_o(grant_o), .timeout_o(timeout_o)
    );

    // Slave: acks after slave_lat stalled cycles, one-cycle ACK pulses.
    always begin
        @(posedge clk);
        #2;
        if (ack_i) begin
            ack_i = 1'b0;
            scnt  = 0;
        end else if (slave_en && cyc_o && stb_o) begin
            if (scnt >= slave_lat) begin
                ack_i = 1'b1;
                dat_i = adr_o ^ K;
                scnt  = 0;
            end else begin
                scnt++;
            end
        end else begin
            scnt = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int m, input logic [31:0] d);
        exp_t e;
        e.m = m;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        for (int m = 0; m < 2; m++) begin
            if (a_ack_o[m]) begin
                acked[m] = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_ack", m, 128'hFF);
                end else begin
                    e = sb.pop_front();
                    chk("ack_master", m, e.m);
                    chk("ack_data", a_dat_o[32*m +: 32], e.data);
                    chk("other_dat_zero", a_dat_o[32*(1-m) +: 32], 0);
                end
            end
        end
        chk("grant_onehot0", $onehot0(grant_o), 1);
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int m, input string name);
        int n = 0;
        while (!acked[m] && n < 40) begin
            tick();
            sample();
            n++;
        end
        chk(name, acked[m], 1);
    endtask

    task automatic run_vec(input vec_t v);
        a_adr = {~v.adr, ~v.adr};  a_adr[32*v.m +: 32] = v.adr;
        a_dat = {~v.wdat, ~v.wdat}; a_dat[32*v.m +: 32] = v.wdat;
        a_sel = {~v.sel, ~v.sel};  a_sel[4*v.m +: 4] = v.sel;
        a_we  = {~v.we, ~v.we};    a_we[v.m] = v.we;
        a_stb = '0; a_cyc = '0; a_stb[v.m] = 1'b1; a_cyc[v.m] = 1'b1;
        slave_lat = v.lat;
        acked = '0;
        push(v.m, v.exp_rdata);
        sample();
        chk("arb_latency", {grant_o, cyc_o}, 0);
        tick();
        sample();
        chk("bus_mux", {grant_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o},
            {v.exp_grant, 1'b1, 1'b1, v.we, v.sel, v.adr, v.wdat});
        wait_ack(v.m, "vec_ack");
        tick();
        a_cyc = '0; a_stb = '0;
        sample();
        tick();
    endtask

    // Both masters request together; grant sequence and idle gap are recorded.
    task automatic run_pair(input logic [31:0] base);
        logic [9:0] trace = '0;
        logic [1:0] prev = '0;
        int ntr = 0, gap = 0;
        bit seen0 = 1'b0, seen1 = 1'b0;
        a_adr = {base + 32'h10, base}; a_we = '0; a_sel = 8'hFF;
        a_cyc = 2'b11; a_stb = 2'b11; acked = '0; slave_lat = 0;
        push(0, base ^ K);
        push(1, (base + 32'h10) ^ K);
        for (int n = 0; n < 40; n++) begin
            sample();
            if (ntr == 0 || grant_o != prev) begin
                if (ntr < 5) trace = {trace[7:0], grant_o};
                ntr++;
                prev = grant_o;
            end
            if (grant_o == 2'b01) seen0 = 1'b1;
            if (grant_o == 2'b10) seen1 = 1'b1;
            if (seen0 && !seen1 && grant_o == 2'b00) gap++;
            tick();
            if (acked[0]) begin a_cyc[0] = 1'b0; a_stb[0] = 1'b0; end
            if (acked[1]) begin a_cyc[1] = 1'b0; a_stb[1] = 1'b0; end
            if (acked == 2'b11 && ntr >= 5) break;
        end
        chk("grant_seq", trace, 10'b00_01_00_10_00);
        chk("grant_changes", ntr, 5);
        chk("idle_gap", gap, 1);
    endtask

    task automatic multi_beat();
        logic [31:0] b = 32'h3000_0200, a0 = 32'h3000_0F00;
        int beats = 0;
        bit m0_on = 1'b0, m0_done = 1'b0, seen_m1 = 1'b0;
        a_adr = {b, a0}; a_we = '0; a_sel = 8'hFF; a_cyc = 2'b10; a_stb = 2'b10;
        acked = '0; slave_lat = 1;
        push(1, b ^ K); push(1, (b + 32'd4) ^ K); push(1, (b + 32'd8) ^ K); push(0, a0 ^ K);
        for (int n = 0; n < 80; n++) begin
            sample();
            if (grant_o == 2'b10) begin
                seen_m1 = 1'b1;
                chk("m1_adr_not_m0", adr_o == a0, 0);
            end
            tick();
            if (seen_m1 && !m0_on) begin a_cyc[0] = 1'b1; a_stb[0] = 1'b1; m0_on = 1'b1; end
            if (acked[1]) begin
                acked[1] = 1'b0;
                beats++;
                if (beats == 3) begin a_cyc[1] = 1'b0; a_stb[1] = 1'b0; end
                else a_adr[63:32] = b + 32'(4 * beats);
            end
            if (acked[0]) begin
                a_cyc[0] = 1'b0; a_stb[0] = 1'b0; m0_done = 1'b1;
                break;
            end
        end
        chk("m1_beats", beats, 3);
        chk("m0_served_after", m0_done, 1);
        sample();
        tick();
    endtask

    initial begin
        vecs[0] = '{0, 32'h3000_0004, 1'b0, 4'hF, 32'h0000_0000, 2, 2'b01, 32'h0000_1234};
        vecs[1] = '{1, 32'h3000_0100, 1'b1, 4'h3, 32'hCAFE_0001, 0, 2'b10, 32'h0000_1330};
        vecs[2] = '{0, 32'h2000_0008, 1'b1, 4'h1, 32'h1111_2222, 1, 2'b01, 32'h1000_1238};
        vecs[3] = '{1, 32'h3000_0004, 1'b0, 4'hC, 32'h0000_0000, 3, 2'b10, 32'h0000_1234};
        vecs[4] = '{0, 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0000_0000, 0, 2'b01, 32'hCFFF_EDCC};

        // Requests held during reset must not be granted.
        a_cyc = 2'b11; a_stb = 2'b11;
        tick();
        chk("reset_bus", {grant_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, timeout_o}, 0);
        chk("reset_ret", {a_ack_o, a_dat_o}, 0);
        a_cyc = '0; a_stb = '0;
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_pair(32'h3000_1000);
        run_pair(32'h3000_2000);

        multi_beat();

        // Reset mid-cycle drops the bus immediately.
        slave_en = 1'b0;
        a_adr[31:0] = 32'h3000_0500; a_cyc = 2'b01; a_stb = 2'b01;
        sample();
        tick();
        sample();
        chk("busy_before_rst", {grant_o, cyc_o, stb_o}, {2'b01, 1'b1, 1'b1});
        #1 rst = 1'b1;
        #1 chk("rst_async", {grant_o, cyc_o, stb_o}, 0);
        a_cyc = '0; a_stb = '0;
        tick();
        rst = 1'b0;
        slave_en = 1'b1;
        run_pair(32'h3000_3000);

        slave_en = 1'b0;
        acked = '0;
        a_adr[31:0] = 32'h3000_0040; a_cyc = 2'b01; a_stb = 2'b01;
`ifdef WB_ARB_TIMEOUT_EN
        begin
            int k = 0;
            push(0, 32'hDEAD_BEEF);
            sample();
            while (grant_o != 2'b01 && k < 10) begin tick(); sample(); k++; end
            k = 0;
            while (!timeout_o && k < 40) begin tick(); sample(); k++; end
            chk("tmo_latency", k, 8);
            chk("tmo_ack", acked[0], 1);
            chk("tmo_bus_idle", {cyc_o, stb_o}, 0);
            tick();
            a_cyc = '0; a_stb = '0;
            sample();
            tick();
            slave_en = 1'b1;
        end
`else
        for (int n = 0; n < 100; n++) begin sample(); tick(); end
        sample();
        chk("stall_held", {cyc_o, stb_o, timeout_o, a_ack_o}, 5'b11000);
        push(0, 32'h3000_0040 ^ K);
        slave_en = 1'b1;
        wait_ack(0, "stall_release_ack");
        tick();
        a_cyc = '0; a_stb = '0;
        sample();
        tick();
`endif
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
